led_cursor: RTL and testbench
=============================

LED_CURSOR -- requirements
Module: led_cursor

Interface
REQ-001 Parameter WIDTH, default 16: number of LEDs, legal range 2..64.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a button level change, minimum 1.
REQ-003 Parameter WRAP, default 0: 0 saturates at the end positions; 1 wraps around.
REQ-004 Parameter START_POS, default WIDTH-1: position loaded at reset.
REQ-005 Parameters REPEAT_DELAY (default 50000000) and REPEAT_PERIOD (default 10000000): auto-repeat timing in cycles.
REQ-006 clk  input  1  system clock; all state on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 btnR  input  1  raw asynchronous button; a press moves the lit LED toward bit 0.
REQ-009 btnL  input  1  raw asynchronous button; a press moves the lit LED toward bit WIDTH-1.
REQ-010 led  output  WIDTH  one-hot, led[pos]=1, registered.
REQ-011 pos  output  clog2(WIDTH)  current position, registered.
REQ-012 at_min / at_max  output  1 each  high when pos==0 / pos==WIDTH-1.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser, then a debouncer, then a rising-edge detector that produces a 1-cycle press pulse.
REQ-014 The debouncer SHALL change its output level only after the synchronised input has differed from that level for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 Latency: pos/led SHALL update on the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge that samples the button high, provided the input stays stable.
REQ-016 Press pulse on R only: pos-1; if pos==0, pos stays 0 (WRAP=0) or becomes WIDTH-1 (WRAP=1).
REQ-017 Press pulse on L only: pos+1; if pos==WIDTH-1, pos stays (WRAP=0) or becomes 0 (WRAP=1).
REQ-018 Pulses on R and L in the same cycle SHALL leave pos unchanged.
REQ-019 A held button SHALL produce exactly one move unless auto-repeat is compiled in (REQ-024).
REQ-020 led SHALL always be exactly one-hot; pos, led, at_min and at_max SHALL update on the same edge.

Reset
REQ-021 rst_n low SHALL immediately set pos=START_POS, led=1<<START_POS and at_min/at_max to match, clear all debounce and repeat counters, force the debounced levels to 0 and clear the edge-detector history.
REQ-022 A button held across reset release SHALL register as a new press once debounced; reset in the middle of a debounce or repeat cycle discards it.

Configuration
REQ-023 The macro LED_CURSOR_AUTOREPEAT_EN SHALL select the auto-repeat feature.
REQ-024 With the macro defined, a debounced button held alone gives a first extra move REPEAT_DELAY cycles after its press pulse, then one move every REPEAT_PERIOD cycles until release. Holding both buttons suspends repeat and resets its timer. Saturation and wrap follow REQ-016/017.
REQ-025 Without the macro, no repeat counter logic SHALL be synthesised, and behaviour is per REQ-019.

Structure
REQ-026 Package led_cursor_pkg SHALL hold the default parameter constants and the move-direction enum (NONE, DEC, INC).
REQ-027 Sub-module btn_debounce (synchroniser + debounce counter + rise pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.
REQ-028 The position register, move arbitration and optional repeat timer SHALL live in led_cursor.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8, START_POS=7, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Reset, then btnR held high for 10 cycles -> led goes from 0x80 to 0x40 exactly 7 edges after the first sampled-high edge; no further change while held (macro off).
REQ-030 btnR high for 3 cycles, low for 1, high for 3 -> no move (glitch rejected).
REQ-031 WRAP=0: 8 clean btnR presses from 0x80 -> led reaches 0x01 after 7 presses with at_min=1; the 8th press leaves 0x01. WRAP=1: the 8th press gives 0x80 and at_max=1.
REQ-032 btnR and btnL rise in the same cycle and are both held -> led unchanged; release both -> no move.
REQ-033 Macro on, btnL held 50 cycles from pos 0 -> moves to 1, then to 2 twenty cycles after the press pulse, then +1 every 5 cycles, saturating at 7.
REQ-034 rst_n pulsed low mid-debounce, with pos at 3 -> led=0x80 asynchronously; the held button then moves to 0x40 after 7 edges from the release of rst_n.

Source files
------------

// File: rtl/led_cursor_pkg.sv
`timescale 1ns/1ps
// Shared defaults, move-direction type and position-step helper for the led_cursor block.
package led_cursor_pkg;

    localparam int DEF_WIDTH           = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_WRAP            = 0;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    typedef enum logic [1:0] {
        NONE,
        DEC,
        INC
    } moveDir_t;

    // Next cursor position for one move; ends either saturate or wrap.
    function automatic int stepPos(input int curPos, input moveDir_t dir,
                                   input int width, input bit wrap);
        int nextPos;
        nextPos = curPos;
        case (dir)
            DEC: begin
                if (curPos == 0) nextPos = wrap ? width - 1 : 0;
                else             nextPos = curPos - 1;
            end
            INC: begin
                if (curPos == width - 1) nextPos = wrap ? 0 : curPos;
                else                     nextPos = curPos + 1;
            end
            default: nextPos = curPos;
        endcase
        return nextPos;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// One button: 2-flop synchroniser, stable-count debouncer and rise pulse.
// The debounced level port only exists when LED_CURSOR_AUTOREPEAT_EN is defined.
module btn_debounce
    import led_cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
`ifdef LED_CURSOR_AUTOREPEAT_EN
    output logic level,
`endif
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    syncReg;
    logic [CW-1:0] cntReg;
    logic          levelReg;
    logic          prevReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg  <= '0;
            cntReg   <= '0;
            levelReg <= 1'b0;
            prevReg  <= 1'b0;
        end else begin
            syncReg <= {syncReg[0], btn};
            prevReg <= levelReg;
            // Any sample agreeing with the current level restarts the count.
            if (syncReg[1] != levelReg) begin
                if (cntReg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    levelReg <= syncReg[1];
                    cntReg   <= '0;
                end else begin
                    cntReg <= cntReg + 1'b1;
                end
            end else begin
                cntReg <= '0;
            end
        end
    end

    // Combinational from registers so the move lands on the edge after the level rises.
    assign press = levelReg & ~prevReg;

`ifdef LED_CURSOR_AUTOREPEAT_EN
    assign level = levelReg;
`endif

endmodule

// File: rtl/led_cursor.sv
`timescale 1ns/1ps
// One-hot LED cursor moved by two debounced buttons (R toward bit 0, L toward bit WIDTH-1).
// Define LED_CURSOR_AUTOREPEAT_EN to add hold-to-repeat.
module led_cursor
    import led_cursor_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WRAP            = DEF_WRAP,
    parameter int START_POS       = WIDTH - 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btnR,
    input  logic                     btnL,
    output logic [WIDTH-1:0]         led,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     at_min,
    output logic                     at_max
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LED_RST = {{(WIDTH-1){1'b0}}, 1'b1} << START_POS;

    if (WIDTH < 2 || WIDTH > 64 || START_POS < 0 || START_POS >= WIDTH ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
        $error("led_cursor: illegal parameter set");
    end

    logic [1:0] rawBtn;
    logic [1:0] btnPress;
`ifdef LED_CURSOR_AUTOREPEAT_EN
    logic [1:0] btnLevel;
`endif

    assign rawBtn = {btnL, btnR};

    for (genvar gi = 0; gi < 2; gi++) begin : gBtn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDebounce (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (rawBtn[gi]),
`ifdef LED_CURSOR_AUTOREPEAT_EN
            .level (btnLevel[gi]),
`endif
            .press (btnPress[gi])
        );
    end

`ifdef LED_CURSOR_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rptCntReg;
    logic          rptArmedReg;
    logic          heldAlone;
    logic          pressAny;
    logic          rptFire;
    logic [RW-1:0] rptTarget;

    assign heldAlone = btnLevel[0] ^ btnLevel[1];
    assign pressAny  = btnPress[0] | btnPress[1];
    assign rptTarget = rptArmedReg ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rptFire   = heldAlone & ~pressAny & (rptCntReg == rptTarget);

    // Timer restarts on every press and whenever zero or both buttons are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptCntReg   <= '0;
            rptArmedReg <= 1'b0;
        end else if (!heldAlone || pressAny) begin
            rptCntReg   <= '0;
            rptArmedReg <= 1'b0;
        end else if (rptFire) begin
            rptCntReg   <= '0;
            rptArmedReg <= 1'b1;
        end else begin
            rptCntReg <= rptCntReg + 1'b1;
        end
    end
`endif

    moveDir_t moveDir;

    always_comb begin
        moveDir = NONE;
        if (btnPress[0] ^ btnPress[1]) begin
            moveDir = btnPress[0] ? DEC : INC;
        end
`ifdef LED_CURSOR_AUTOREPEAT_EN
        else if (rptFire) begin
            moveDir = btnLevel[0] ? DEC : INC;
        end
`endif
    end

    logic [PW-1:0]    posReg;
    logic [WIDTH-1:0] ledReg;
    logic             minReg;
    logic             maxReg;
    logic [PW-1:0]    posNext;
    logic [WIDTH-1:0] ledNext;

    assign posNext = PW'(stepPos(int'(posReg), moveDir, WIDTH, WRAP != 0));

    for (genvar gi = 0; gi < WIDTH; gi++) begin : gLed
        assign ledNext[gi] = (posNext == PW'(gi));
    end

    // All four outputs share one register stage so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posReg <= PW'(START_POS);
            ledReg <= LED_RST;
            minReg <= (START_POS == 0);
            maxReg <= (START_POS == WIDTH - 1);
        end else if (moveDir != NONE) begin
            posReg <= posNext;
            ledReg <= ledNext;
            minReg <= (posNext == '0);
            maxReg <= (posNext == PW'(WIDTH - 1));
        end
    end

    assign pos    = posReg;
    assign led    = ledReg;
    assign at_min = minReg;
    assign at_max = maxReg;

endmodule

// File: tb/tb_led_cursor.sv
`timescale 1ns/1ps
// Directed bench for led_cursor: a saturating and a wrapping instance share the buttons.
module tb_led_cursor;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SP = 7;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnR = 1'b0;
    logic       btnL = 1'b0;
    logic [7:0] led0, led1;
    logic [2:0] pos0, pos1;
    logic       min0, max0, min1, max1;

    led_cursor #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(0), .START_POS(SP),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dutSat (
        .clk(clk), .rst_n(rst_n), .btnR(btnR), .btnL(btnL),
        .led(led0), .pos(pos0), .at_min(min0), .at_max(max0));

    led_cursor #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(1), .START_POS(SP),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dutWrap (
        .clk(clk), .rst_n(rst_n), .btnR(btnR), .btnL(btnL),
        .led(led1), .pos(pos1), .at_min(min1), .at_max(max1));

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          model0 = SP;
    int          model1 = SP;
    logic [12:0] sb0[$];
    logic [12:0] sb1[$];

    function automatic logic [12:0] pack(input int p);
        logic [7:0] oneHot;
        oneHot = 8'd1 << p;
        return {(p == W - 1), (p == 0), 3'(p), oneHot};
    endfunction

    function automatic int stepModel(input int p, input bit dec, input bit wrap);
        if (dec) return (p == 0) ? (wrap ? W - 1 : 0) : p - 1;
        return (p == W - 1) ? (wrap ? 0 : W - 1) : p + 1;
    endfunction

    // Edge k counts from the first edge sampling the button high; hold = high cycles.
    function automatic bit isMove(input int k, input int hold);
        if (hold < D) return 1'b0;
        if (k == D + 3) return 1'b1;
`ifdef LED_CURSOR_AUTOREPEAT_EN
        if (k >= D + 3 + RD && k <= hold + D + 2 && ((k - (D + 3 + RD)) % RP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic expectNow();
        sb0.push_back(pack(model0));
        sb1.push_back(pack(model1));
    endtask

    task automatic check(input string tag);
        logic [12:0] e0, e1, o0, o1;
        e0 = sb0.pop_front();
        e1 = sb1.pop_front();
        o0 = {max0, min0, pos0, led0};
        o1 = {max1, min1, pos1, led1};
        total++;
        assert (o0 === e0) else begin
            bad++;
            $error("FAIL %s sat observed=%h expected=%h", tag, o0, e0);
        end
        total++;
        assert (o1 === e1) else begin
            bad++;
            $error("FAIL %s wrap observed=%h expected=%h", tag, o1, e1);
        end
        $display("t=%0t %s led0=%h led1=%h", $time, tag, led0, led1);
    endtask

    // Called at a negedge: holds r/l for 'hold' cycles, then releases for 'tail' cycles.
    task automatic runPress(input bit r, input bit l, input int hold, input int tail,
                            input string tag);
        for (int k = 1; k <= hold + tail; k++) begin
            btnR = r && (k <= hold);
            btnL = l && (k <= hold);
            if ((r ^ l) && isMove(k, hold)) begin
                model0 = stepModel(model0, r, 1'b0);
                model1 = stepModel(model1, r, 1'b1);
            end
            expectNow();
            @(posedge clk);
            @(negedge clk);
            check(tag);
        end
    endtask

    task automatic asyncReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model0 = SP;
        model1 = SP;
        expectNow();
        check(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        expectNow();
        check("reset");
        rst_n = 1'b1;

        runPress(1'b1, 1'b0, 10, 8, "holdR");

        runPress(1'b1, 1'b0, 3, 1, "glitchA");
        runPress(1'b1, 1'b0, 3, 8, "glitchB");

        runPress(1'b1, 1'b1, 10, 8, "bothHeld");

        asyncReset("rstIdle");
        for (int i = 0; i < 8; i++) runPress(1'b1, 1'b0, 5, 8, "pressR");

`ifdef LED_CURSOR_AUTOREPEAT_EN
        runPress(1'b0, 1'b1, 50, 8, "repeatL");
`endif

        asyncReset("rstAgain");
        for (int i = 0; i < 4; i++) runPress(1'b1, 1'b0, 5, 8, "toPos3");

        btnR = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expectNow();
            @(posedge clk);
            @(negedge clk);
            check("midDebounce");
        end
        asyncReset("rstMid");
        runPress(1'b1, 1'b0, 10, 8, "afterRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
